// File: rtl/robot_pkg.sv
// robot_pkg: decision states and {front,turn,remove} action encodings
package robot_pkg;
    typedef enum logic [2:0] {S_STOP, S_FWD, S_TURN, S_REMOVE, S_ROT} state_t;
    localparam logic [2:0] ACT_STOP   = 3'b000;
    localparam logic [2:0] ACT_FWD    = 3'b100;
    localparam logic [2:0] ACT_TURN   = 3'b010;
    localparam logic [2:0] ACT_REMOVE = 3'b001;
endpackage

// File: rtl/robot_ctrl.sv
// robot_ctrl: left-wall-following decision FSM, one action per clock edge
module robot_ctrl
    import robot_pkg::*;
#(
    parameter int RIGHT_TURN_STEPS = 3
) (
    input  logic clock_50,
    input  logic reset_flag,
    input  logic head,
    input  logic left,
    input  logic under,
    input  logic barrier,
    output logic front,
    output logic turn,
    output logic remove
);
    localparam int CW = $clog2(RIGHT_TURN_STEPS + 1);
    state_t state_q, state_d;
    logic [CW-1:0] rot_cnt_q, rot_cnt_d;
    always_ff @(posedge clock_50 or posedge reset_flag) begin
        if (reset_flag) begin
            state_q   <= S_STOP;
            rot_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            rot_cnt_q <= rot_cnt_d;
        end
    end
    always_comb begin
        state_d   = state_q;
        rot_cnt_d = rot_cnt_q;
        if (state_q == S_ROT) begin
            // the last step of a right turn lands in S_TURN so the left-turn guard applies
            state_d   = (rot_cnt_q == CW'(1)) ? S_TURN : S_ROT;
            rot_cnt_d = rot_cnt_q - CW'(1);
        end else if (under)
            state_d = S_STOP;
        else if (barrier)
            state_d = S_REMOVE;
        else if (!left && state_q != S_TURN)
            state_d = S_TURN;
        else if (!head)
            state_d = S_FWD;
        else begin
            state_d   = (RIGHT_TURN_STEPS == 1) ? S_TURN : S_ROT;
            rot_cnt_d = CW'(RIGHT_TURN_STEPS - 1);
        end
    end
    always_comb
        {front, turn, remove} = (state_q == S_FWD)                        ? ACT_FWD    :
                                (state_q == S_TURN || state_q == S_ROT)   ? ACT_TURN   :
                                (state_q == S_REMOVE)                     ? ACT_REMOVE : ACT_STOP;
endmodule

// File: tb/tb_robot_ctrl.sv
// tb_robot_ctrl: directed checks of the wall-follower decision sequence
module tb_robot_ctrl;
    logic clock_50 = 1'b0;
    logic reset_flag = 1'b1;
    logic head = 1'b0, left = 1'b1, under = 1'b0, barrier = 1'b0;
    logic front, turn, remove;
    int errors = 0;
    int checks = 0;

    robot_ctrl #(.RIGHT_TURN_STEPS(3)) dut (
        .clock_50(clock_50), .reset_flag(reset_flag),
        .head(head), .left(left), .under(under), .barrier(barrier),
        .front(front), .turn(turn), .remove(remove)
    );

    always #5 clock_50 = ~clock_50;

    task automatic check(input string tag, input logic [2:0] exp);
        checks++;
        assert ({front, turn, remove} === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%b expected=%b", tag, {front, turn, remove}, exp);
        end
    endtask

    task automatic step(input logic h, input logic l, input logic u, input logic b,
                        input string tag, input logic [2:0] exp);
        head = h; left = l; under = u; barrier = b;
        @(posedge clock_50);
        #1;
        check(tag, exp);
    endtask

    initial begin
        repeat (2) @(posedge clock_50);
        #1;
        check("reset_hold", 3'b000);
        reset_flag = 1'b0;
        #1;
        check("reset_release", 3'b000);

        step(0, 1, 0, 0, "t1_fwd", 3'b100);

        step(0, 0, 0, 0, "t2_turn_a", 3'b010);
        step(0, 0, 0, 0, "t2_fwd_a", 3'b100);
        step(0, 0, 0, 0, "t2_turn_b", 3'b010);
        step(0, 0, 0, 0, "t2_fwd_b", 3'b100);

        step(1, 1, 0, 0, "t3_rot1", 3'b010);
        step(0, 1, 1, 1, "t3_rot2_ignore", 3'b010);
        step(0, 0, 1, 1, "t3_rot3_ignore", 3'b010);
        step(0, 0, 0, 0, "t3_after_rot_no_left", 3'b100);

        step(0, 1, 0, 1, "t4_remove1", 3'b001);
        step(0, 1, 0, 1, "t4_remove2", 3'b001);
        step(0, 1, 0, 1, "t4_remove3", 3'b001);
        step(0, 1, 0, 0, "t4_fwd", 3'b100);

        step(0, 1, 1, 1, "t5_under_barrier", 3'b000);
        step(0, 0, 1, 0, "t5_under_left0", 3'b000);
        step(1, 1, 1, 0, "t5_under_head", 3'b000);
        step(0, 1, 0, 0, "t5_release_fwd", 3'b100);

        step(1, 1, 0, 0, "t6_rot1", 3'b010);
        step(1, 1, 0, 0, "t6_rot2", 3'b010);
        #3;
        reset_flag = 1'b1;
        #1;
        check("t6_async_reset", 3'b000);
        @(posedge clock_50);
        #1;
        check("t6_reset_held", 3'b000);
        reset_flag = 1'b0;
        step(0, 1, 0, 0, "t6_no_resume", 3'b100);

        step(1, 0, 0, 0, "t7_left_open", 3'b010);
        step(1, 0, 0, 0, "t7_guard_rot", 3'b010);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
